// File: rtl/comparador_prioridade_display_pkg.sv
// Shared definitions for the two-user arbitration front-end: code widths,
// user-code constants, priority encodings and the 7-segment digit table.
package comparador_prioridade_display_pkg;

  localparam int W_USER = 3;
  localparam int W_FUNC = 3;
  localparam int W_SEG  = 7;

  // User codes; rank is the unsigned value of the code.
  localparam logic [W_USER-1:0] USER_NONE      = 3'b000;
  localparam logic [W_USER-1:0] USER_STD       = 3'b001;
  localparam logic [W_USER-1:0] USER_ADMIN     = 3'b101;
  localparam logic [W_USER-1:0] USER_AUTOPILOT = 3'b111;

  // Raw comparison result; bit 0 selects user 0, bit 1 selects user 1.
  typedef enum logic [1:0] {
    PRIO_NONE  = 2'b00,
    PRIO_USER0 = 2'b01,
    PRIO_USER1 = 2'b10,
    PRIO_BOTH  = 2'b11
  } prio_t;

  // Segments {G,F,E,D,C,B,A}, active-low.
  localparam logic [W_SEG-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [W_SEG-1:0] SEG_TABLE [8] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000   // 7
  };

  // Segment pattern for a 3-bit digit.
  function automatic logic [W_SEG-1:0] seg_of(input logic [W_USER-1:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/comparador_prioridade_display_seven_seg_decoder.sv
// Combinational 3-bit to 7-segment decoder with blanking enable.
// Outputs are active-low, segment order {G,F,E,D,C,B,A}.
module seven_seg_decoder
  import comparador_prioridade_display_pkg::*;
(
  input  logic [W_USER-1:0] i_digit,
  input  logic              i_en,
  output logic [W_SEG-1:0]  o_seg
);

  // Look up the digit pattern, or blank the display when disabled.
  always_comb begin
    // NOTE: assigning a default first means every path drives o_seg, so no latch is inferred.
    o_seg = SEG_BLANK;
    if (i_en) begin
      o_seg = seg_of(i_digit);
    end
  end

endmodule

// File: rtl/comparador_prioridade_display.sv
// Registered arbitration front-end for the two-user control panel.
// Ranks the two user codes, checks whether both users requested the same
// function, and shows the lower-priority user's code on a 7-segment digit.
// Every output is registered: one clock from input change to output.
module comparador_prioridade_display
  import comparador_prioridade_display_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [W_USER-1:0] user0,
  input  logic [W_USER-1:0] user1,
  input  logic [W_FUNC-1:0] func0,
  input  logic [W_FUNC-1:0] func1,
  input  logic              disp_en,
  output logic [1:0]        prio_comp,
  output logic [1:0]        prio_sel,
  output logic              func_equal,
  output logic              autopilot,
  output logic [W_USER-1:0] loser_user,
  output logic [W_SEG-1:0]  seg,
  output logic              dp
);

  prio_t             w_prio;
  logic [W_USER-1:0] w_loser;
  logic              w_func_equal;
  logic [1:0]        w_prio_sel;
  logic              w_autopilot;
  logic [W_SEG-1:0]  w_seg;

  logic [1:0]        r_prio_comp;
  logic [1:0]        r_prio_sel;
  logic              r_func_equal;
  logic              r_autopilot;
  logic [W_USER-1:0] r_loser_user;
  logic [W_SEG-1:0]  r_seg;
  logic              r_dp;

  // Rank the two user codes; equal non-autopilot, non-none codes tie to user 0.
  always_comb begin
    w_prio  = PRIO_NONE;
    w_loser = user1;
    if (user0 > user1) begin
      w_prio  = PRIO_USER0;
      w_loser = user1;
    end else if (user1 > user0) begin
      w_prio  = PRIO_USER1;
      w_loser = user0;
    end else if (user0 == USER_AUTOPILOT) begin
      w_prio  = PRIO_BOTH;
    end else if (user0 == USER_NONE) begin
      w_prio  = PRIO_NONE;
    end else begin
      w_prio  = PRIO_USER0;
    end
  end

  // Differing function requests force both users to execute.
  always_comb begin
    w_func_equal = (func0 == func1);
    w_prio_sel   = w_prio | {2{~w_func_equal}};
    w_autopilot  = (w_prio == PRIO_BOTH);
  end

  // Digit for the lower-priority user, decoded from this cycle's inputs.
  seven_seg_decoder u_seven_seg_decoder (
    .i_digit (w_loser),
    .i_en    (disp_en),
    .o_seg   (w_seg)
  );

  // Single output register stage; synchronous reset dominates the inputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      r_prio_comp  <= PRIO_NONE;
      r_prio_sel   <= 2'b00;
      r_func_equal <= 1'b0;
      r_autopilot  <= 1'b0;
      r_loser_user <= USER_NONE;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
    end else begin
      r_prio_comp  <= w_prio;
      r_prio_sel   <= w_prio_sel;
      r_func_equal <= w_func_equal;
      r_autopilot  <= w_autopilot;
      r_loser_user <= w_loser;
      r_seg        <= w_seg;
      r_dp         <= 1'b1;
    end
  end

  assign prio_comp  = r_prio_comp;
  assign prio_sel   = r_prio_sel;
  assign func_equal = r_func_equal;
  assign autopilot  = r_autopilot;
  assign loser_user = r_loser_user;
  assign seg        = r_seg;
  assign dp         = r_dp;

endmodule

// File: tb/tb_comparador_prioridade_display.sv
// Self-checking bench for comparador_prioridade_display: directed steps
// followed by randomized traffic against a behavioural reference model.
module tb_comparador_prioridade_display;

  logic       clk;
  logic       reset;
  logic [2:0] user0, user1, func0, func1;
  logic       disp_en;
  logic [1:0] prio_comp, prio_sel;
  logic       func_equal, autopilot, dp;
  logic [2:0] loser_user;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_pc, exp_ps;
  logic       exp_fe, exp_ap, exp_dp;
  logic [2:0] exp_lu;
  logic [6:0] exp_seg;

  logic [6:0] digit_tbl [8];

  comparador_prioridade_display dut (
    .clk        (clk),
    .reset      (reset),
    .user0      (user0),
    .user1      (user1),
    .func0      (func0),
    .func1      (func1),
    .disp_en    (disp_en),
    .prio_comp  (prio_comp),
    .prio_sel   (prio_sel),
    .func_equal (func_equal),
    .autopilot  (autopilot),
    .loser_user (loser_user),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected outputs from the arbitration rules, using integer ranks.
  task automatic model(input logic [2:0] u0, input logic [2:0] u1,
                       input logic [2:0] f0, input logic [2:0] f1, input logic en);
    int a, b, winner;
    a = int'(u0);
    b = int'(u1);
    if (a > b)        begin winner = 1; exp_lu = u1; end
    else if (b > a)   begin winner = 2; exp_lu = u0; end
    else if (a == 7)  begin winner = 3; exp_lu = 3'd7; end
    else if (a == 0)  begin winner = 0; exp_lu = 3'd0; end
    else              begin winner = 1; exp_lu = u1; end
    exp_pc  = 2'(winner);
    exp_fe  = (int'(f0) == int'(f1));
    exp_ps  = exp_fe ? exp_pc : 2'b11;
    exp_ap  = (winner == 3);
    exp_seg = en ? digit_tbl[exp_lu] : 7'h7f;
    exp_dp  = 1'b1;
  endtask

  task automatic set_reset_exp();
    exp_pc = 2'b00; exp_ps = 2'b00; exp_fe = 1'b0; exp_ap = 1'b0;
    exp_lu = 3'b000; exp_seg = 7'b1111111; exp_dp = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".prio_comp"},  7'(prio_comp),  7'(exp_pc));
    check({tag, ".prio_sel"},   7'(prio_sel),   7'(exp_ps));
    check({tag, ".func_equal"}, 7'(func_equal), 7'(exp_fe));
    check({tag, ".autopilot"},  7'(autopilot),  7'(exp_ap));
    check({tag, ".loser_user"}, 7'(loser_user), 7'(exp_lu));
    check({tag, ".seg"},        seg,            exp_seg);
    check({tag, ".dp"},         7'(dp),         7'(exp_dp));
  endtask

  // Apply one input vector away from the edge, then check after the next edge.
  task automatic step(input string tag, input logic [2:0] u0, input logic [2:0] u1,
                      input logic [2:0] f0, input logic [2:0] f1, input logic en);
    user0 = u0; user1 = u1; func0 = f0; func1 = f1; disp_en = en;
    model(u0, u1, f0, f1, en);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    digit_tbl[0] = 7'b1000000; digit_tbl[1] = 7'b1111001;
    digit_tbl[2] = 7'b0100100; digit_tbl[3] = 7'b0110000;
    digit_tbl[4] = 7'b0011001; digit_tbl[5] = 7'b0010010;
    digit_tbl[6] = 7'b0000010; digit_tbl[7] = 7'b1111000;

    // 1: reset held for two clocks with arbitrary, display-enabled inputs.
    reset = 1'b1;
    user0 = 3'b111; user1 = 3'b011; func0 = 3'b010; func1 = 3'b110; disp_en = 1'b1;
    set_reset_exp();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all("reset");
    end
    reset = 1'b0;

    // 2: admin over standard user, same function, display off.
    step("t2", 3'b101, 3'b001, 3'b001, 3'b001, 1'b0);
    check("t2.spec_sel", 7'(prio_sel), 7'b01);

    // 3: different functions force both-execute; digit 1 shown.
    step("t3", 3'b101, 3'b001, 3'b010, 3'b001, 1'b1);
    check("t3.spec_seg", seg, 7'b1111001);
    check("t3.spec_sel", 7'(prio_sel), 7'b11);

    // 4: both autopilot.
    step("t4", 3'b111, 3'b111, 3'b101, 3'b101, 1'b0);
    check("t4.spec_pc", 7'(prio_comp), 7'b11);

    // 5: user 1 wins, then reset mid-stream with inputs unchanged.
    step("t5", 3'b001, 3'b101, 3'b011, 3'b011, 1'b1);
    check("t5.spec_pc", 7'(prio_comp), 7'b10);
    reset = 1'b1;
    set_reset_exp();
    @(posedge clk);
    #1;
    check_all("t5.reset");
    reset = 1'b0;

    // Boundary ties: both none, and equal standard codes tie to user 0.
    step("tie_none", 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
    step("tie_std",  3'b001, 3'b001, 3'b100, 3'b100, 1'b1);
    step("tie_adm",  3'b101, 3'b101, 3'b110, 3'b001, 1'b1);

    // 6: sweep the losing code through every digit.
    for (int k = 0; k < 8; k++) begin
      step($sformatf("sweep%0d", k), 3'b111, 3'(k), 3'b000, 3'b000, 1'b1);
      check($sformatf("sweep%0d.tbl", k), seg, digit_tbl[k]);
    end

    // Randomized traffic; functions are biased towards equality.
    for (int n = 0; n < 300; n++) begin
      logic [2:0] r0, r1, rf0, rf1;
      r0  = 3'($urandom_range(0, 7));
      r1  = 3'($urandom_range(0, 7));
      rf0 = 3'($urandom_range(0, 7));
      rf1 = ($urandom_range(0, 1) == 1) ? rf0 : 3'($urandom_range(0, 7));
      step($sformatf("rand%0d", n), r0, r1, rf0, rf1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
